eeprom_rw_sched: RTL and testbench

Sequencer between the board-level wr_en/rd_en controls and the existing I2C byte-level EEPROM driver (AT24C64, 16-bit word address).
- A write request writes BYTE_NUM bytes of a known pattern, honouring the EEPROM write-cycle time between bytes.
- A read request reads the same bytes back and presents each one to the seven-segment display path.
- Arbitrates overlapping write and read requests and retries NACKed transfers.

---
 rtl/eeprom_pkg.sv | 16 +
 rtl/req_edge_det.sv | 24 ++
 rtl/eeprom_rw_sched.sv | 215 +++++++++++++++++++++
 tb/tb_eeprom_rw_sched.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eeprom_pkg.sv
// Shared types and widths for the EEPROM read/write sequencer.
package eeprom_pkg;

  localparam int unsigned EEPROM_ADDR_W = 16;
  localparam int unsigned DATA_W        = 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    WR_TWR,
    RD_REQ,
    RD_WAIT
  } state_e;

endpackage

// File: rtl/req_edge_det.sv
// Registers a request level and emits a one-cycle rising-edge pulse.
module req_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_rise
);

  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= i_level;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/eeprom_rw_sched.sv
// Sequences board-level write/read requests into byte transfers for the I2C EEPROM driver,
// with write-cycle waits, request arbitration and NACK retries.
module eeprom_rw_sched
  import eeprom_pkg::*;
#(
  parameter int unsigned              BYTE_NUM   = 4,
  parameter logic [EEPROM_ADDR_W-1:0] BASE_ADDR  = 16'h0000,
  parameter logic [DATA_W-1:0]        DATA_SEED  = 8'hA5,
  parameter int unsigned              TWR_CYCLES = 250000,
  parameter int unsigned              MAX_RETRY  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_en,
  input  logic                     i_rd_en,
  output logic                     o_i2c_req,
  output logic                     o_i2c_rw,
  output logic [EEPROM_ADDR_W-1:0] o_i2c_addr,
  output logic [DATA_W-1:0]        o_i2c_wdata,
  input  logic                     i_i2c_done,
  input  logic                     i_i2c_ack_err,
  input  logic [DATA_W-1:0]        i_i2c_rdata,
  output logic [DATA_W-1:0]        o_rd_data,
  output logic                     o_rd_valid,
  output logic                     o_busy,
  output logic                     o_err
);

  localparam int unsigned IDX_W = $clog2(BYTE_NUM + 1);
  localparam int unsigned TMR_W = (TWR_CYCLES < 1) ? 1 : $clog2(TWR_CYCLES + 1);
  localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic w_wr_rise;
  logic w_rd_rise;

  req_edge_det u_wr_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_level (i_wr_en),
    .o_rise  (w_wr_rise)
  );

  req_edge_det u_rd_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_level (i_rd_en),
    .o_rise  (w_rd_rise)
  );

  state_e                   r_state, w_state_d;
  logic                     r_wr_pend, w_wr_pend_d;
  logic                     r_rd_pend, w_rd_pend_d;
  logic [IDX_W-1:0]         r_idx, w_idx_d;
  logic [RTY_W-1:0]         r_retry, w_retry_d;
  logic [TMR_W-1:0]         r_tmr, w_tmr_d;
  logic                     r_nack, w_nack_d;
  logic                     r_req, w_req_d;
  logic                     r_rw, w_rw_d;
  logic [EEPROM_ADDR_W-1:0] r_addr, w_addr_d;
  logic [DATA_W-1:0]        r_wdata, w_wdata_d;
  logic [DATA_W-1:0]        r_rd_data, w_rd_data_d;
  logic                     r_rd_valid, w_rd_valid_d;
  logic                     r_err, w_err_d;

  logic w_last;
  logic w_can_retry;
  logic w_tmr_done;

  assign w_last      = (r_idx == IDX_W'(BYTE_NUM - 1));
  assign w_can_retry = (r_retry < RTY_W'(MAX_RETRY));
  assign w_tmr_done  = (r_tmr == TMR_W'(TWR_CYCLES - 1));

  always_comb begin
    w_state_d    = r_state;
    // A new edge while the flag is still set is simply absorbed.
    w_wr_pend_d  = r_wr_pend | w_wr_rise;
    w_rd_pend_d  = r_rd_pend | w_rd_rise;
    w_idx_d      = r_idx;
    w_retry_d    = r_retry;
    w_tmr_d      = r_tmr;
    w_nack_d     = r_nack;
    w_req_d      = r_req;
    w_rw_d       = r_rw;
    w_addr_d     = r_addr;
    w_wdata_d    = r_wdata;
    w_rd_data_d  = r_rd_data;
    w_rd_valid_d = 1'b0;
    w_err_d      = r_err;

    unique case (r_state)
      IDLE: begin
        if (r_wr_pend || r_rd_pend) begin
          w_idx_d   = '0;
          w_retry_d = '0;
          w_nack_d  = 1'b0;
          w_err_d   = 1'b0;
          if (r_wr_pend) begin
            w_wr_pend_d = 1'b0;
            w_state_d   = WR_REQ;
          end else begin
            w_rd_pend_d = 1'b0;
            w_state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        w_req_d   = 1'b1;
        w_rw_d    = 1'b0;
        w_addr_d  = BASE_ADDR + EEPROM_ADDR_W'(r_idx);
        w_wdata_d = DATA_SEED + DATA_W'(r_idx);
        w_state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (i_i2c_done) begin
          w_req_d = 1'b0;
          w_tmr_d = '0;
          if (!i_i2c_ack_err) begin
            w_nack_d  = 1'b0;
            w_state_d = WR_TWR;
          end else if (w_can_retry) begin
            w_retry_d = r_retry + 1'b1;
            w_nack_d  = 1'b1;
            w_state_d = WR_TWR;
          end else begin
            w_err_d   = 1'b1;
            w_state_d = IDLE;
          end
        end
      end
      WR_TWR: begin
        if (w_tmr_done) begin
          w_tmr_d = '0;
          if (r_nack) begin
            w_state_d = WR_REQ;
          end else begin
            w_idx_d   = r_idx + 1'b1;
            w_retry_d = '0;
            w_state_d = w_last ? IDLE : WR_REQ;
          end
        end else begin
          w_tmr_d = r_tmr + 1'b1;
        end
      end
      RD_REQ: begin
        w_req_d   = 1'b1;
        w_rw_d    = 1'b1;
        w_addr_d  = BASE_ADDR + EEPROM_ADDR_W'(r_idx);
        w_state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (i_i2c_done) begin
          w_req_d = 1'b0;
          if (!i_i2c_ack_err) begin
            w_rd_data_d  = i_i2c_rdata;
            w_rd_valid_d = 1'b1;
            w_idx_d      = r_idx + 1'b1;
            w_retry_d    = '0;
            w_state_d    = w_last ? IDLE : RD_REQ;
          end else if (w_can_retry) begin
            w_retry_d = r_retry + 1'b1;
            w_state_d = RD_REQ;
          end else begin
            w_err_d   = 1'b1;
            w_state_d = IDLE;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wr_pend  <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_idx      <= '0;
      r_retry    <= '0;
      r_tmr      <= '0;
      r_nack     <= 1'b0;
      r_req      <= 1'b0;
      r_rw       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_wr_pend  <= w_wr_pend_d;
      r_rd_pend  <= w_rd_pend_d;
      r_idx      <= w_idx_d;
      r_retry    <= w_retry_d;
      r_tmr      <= w_tmr_d;
      r_nack     <= w_nack_d;
      r_req      <= w_req_d;
      r_rw       <= w_rw_d;
      r_addr     <= w_addr_d;
      r_wdata    <= w_wdata_d;
      r_rd_data  <= w_rd_data_d;
      r_rd_valid <= w_rd_valid_d;
      r_err      <= w_err_d;
    end
  end

  assign o_i2c_req   = r_req;
  assign o_i2c_rw    = r_rw;
  assign o_i2c_addr  = r_addr;
  assign o_i2c_wdata = r_wdata;
  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;
  assign o_busy      = (r_state != IDLE);
  assign o_err       = r_err;

endmodule

// File: tb/tb_eeprom_rw_sched.sv
// Directed and randomized checks of eeprom_rw_sched against an I2C driver stub and a
// transaction-level reference model.
module tb_eeprom_rw_sched;

  localparam int unsigned BYTE_NUM  = 4;
  localparam int unsigned TWR       = 16;
  localparam int unsigned MAX_RETRY = 3;
  localparam int unsigned LAT       = 20;
  localparam logic [15:0] BASE      = 16'h0000;
  localparam logic [7:0]  SEED      = 8'hA5;
  localparam int          ALWAYS    = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        done = 1'b0;
  logic        ack_err = 1'b0;
  logic [7:0]  rdata = 8'h00;
  logic        req, rw, rd_valid, busy, err;
  logic [15:0] addr;
  logic [7:0]  wdata, rd_data;

  eeprom_rw_sched #(
    .BYTE_NUM   (BYTE_NUM),
    .BASE_ADDR  (BASE),
    .DATA_SEED  (SEED),
    .TWR_CYCLES (TWR),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wr_en       (wr_en),
    .i_rd_en       (rd_en),
    .o_i2c_req     (req),
    .o_i2c_rw      (rw),
    .o_i2c_addr    (addr),
    .o_i2c_wdata   (wdata),
    .i_i2c_done    (done),
    .i_i2c_ack_err (ack_err),
    .i_i2c_rdata   (rdata),
    .o_rd_data     (rd_data),
    .o_rd_valid    (rd_valid),
    .o_busy        (busy),
    .o_err         (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          t_start;
    int          t_done;
  } xfer_t;

  xfer_t      log_q[$];
  xfer_t      exp_q[$];
  logic [7:0] rdv_q[$];
  logic [7:0] exp_rd_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // I2C driver stub: fixed latency, per-address NACK budget, small memory
  int         stub_nack [0:15];
  logic [7:0] stub_mem  [0:15];

  initial begin
    bit    active;
    int    cnt;
    int    viol;
    xfer_t cur;
    active = 0;
    cnt    = 0;
    viol   = 0;
    forever begin
      @(negedge clk);
      done    = 1'b0;
      ack_err = 1'b0;
      if (rst_n !== 1'b1) begin
        active = 0;
      end else if (active) begin
        if (req !== 1'b1 || rw !== cur.rw || addr !== cur.addr ||
            (!cur.rw && wdata !== cur.wdata)) viol++;
        cnt++;
        if (cnt == LAT) begin
          active = 0;
          done   = 1'b1;
          log_q[log_q.size()-1].t_done = cyc;
          chk("handshake_stable", viol, 0);
          if (stub_nack[cur.addr[3:0]] > 0) begin
            ack_err = 1'b1;
            rdata   = 8'($urandom);
            if (stub_nack[cur.addr[3:0]] != ALWAYS) stub_nack[cur.addr[3:0]]--;
          end else if (!cur.rw) begin
            stub_mem[cur.addr[3:0]] = cur.wdata;
          end else begin
            rdata = stub_mem[cur.addr[3:0]];
          end
        end
      end else if (req === 1'b1) begin
        active      = 1;
        cnt         = 0;
        viol        = 0;
        cur.rw      = rw;
        cur.addr    = addr;
        cur.wdata   = wdata;
        cur.t_start = cyc;
        cur.t_done  = 0;
        log_q.push_back(cur);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rd_valid === 1'b1) rdv_q.push_back(rd_data);
  end

  // Longest busy-low run between sequences, once busy has been seen high
  bit seen_busy = 0;
  int run_len   = 0;
  int gap_max   = 0;
  initial forever begin
    @(negedge clk);
    if (busy === 1'b1) begin
      if (seen_busy && run_len > gap_max) gap_max = run_len;
      seen_busy = 1;
      run_len   = 0;
    end else if (seen_busy) begin
      run_len++;
    end
  end

  // Reference model: expected transfer list and read results from the sequencing rules
  int         mdl_nack [0:15];
  logic [7:0] mdl_mem  [0:15];
  bit         exp_err;

  task automatic model_seq(input bit is_rd);
    xfer_t e;
    exp_err = 0;
    for (int i = 0; i < BYTE_NUM; i++) begin
      int nacks;
      bit ok;
      nacks = 0;
      ok    = 0;
      while (!ok && !exp_err) begin
        e.rw      = is_rd;
        e.addr    = BASE + 16'(i);
        e.wdata   = SEED + 8'(i);
        e.t_start = 0;
        e.t_done  = 0;
        exp_q.push_back(e);
        if (mdl_nack[e.addr[3:0]] > 0) begin
          if (mdl_nack[e.addr[3:0]] != ALWAYS) mdl_nack[e.addr[3:0]]--;
          nacks++;
          if (nacks > MAX_RETRY) exp_err = 1;
        end else begin
          ok = 1;
          if (is_rd) exp_rd_q.push_back(mdl_mem[e.addr[3:0]]);
          else mdl_mem[e.addr[3:0]] = e.wdata;
        end
      end
      if (exp_err) break;
    end
  endtask

  task automatic set_nack(input int a, input int n);
    stub_nack[a] = n;
    mdl_nack[a]  = n;
  endtask

  task automatic clear_nack();
    for (int a = 0; a < 16; a++) set_nack(a, 0);
  endtask

  task automatic clear_queues();
    log_q.delete();
    exp_q.delete();
    rdv_q.delete();
    exp_rd_q.delete();
  endtask

  task automatic pulse_req(input bit w, input bit r);
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    repeat (3) @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int q;
    int n;
    q = 0;
    n = 0;
    while (q < 8 && n < budget) begin
      @(negedge clk);
      n++;
      if (busy === 1'b0 && req === 1'b0) q++;
      else q = 0;
    end
    chk({tag, "_quiet_in_budget"}, (q >= 8), 1);
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_xfer_count"}, log_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < log_q.size(); j++) begin
      chk({tag, "_rw"}, log_q[j].rw, exp_q[j].rw);
      chk({tag, "_addr"}, log_q[j].addr, exp_q[j].addr);
      if (!exp_q[j].rw) chk({tag, "_wdata"}, log_q[j].wdata, exp_q[j].wdata);
      if (j > 0 && !log_q[j].rw && !log_q[j-1].rw)
        chk({tag, "_twr_gap"}, (log_q[j].t_start - log_q[j-1].t_done >= TWR), 1);
    end
    chk({tag, "_rd_count"}, rdv_q.size(), exp_rd_q.size());
    for (int j = 0; j < exp_rd_q.size() && j < rdv_q.size(); j++)
      chk({tag, "_rd_data"}, rdv_q[j], exp_rd_q[j]);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_busy"}, busy, 0);
    clear_queues();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int a = 0; a < 16; a++) begin
      stub_mem[a] = 8'h00;
      mdl_mem[a]  = 8'h00;
    end
    clear_nack();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_req", req, 0);
    chk("reset_busy", busy, 0);
    chk("reset_addr", addr, 0);
    chk("reset_rd_valid", rd_valid, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_no_req", log_q.size(), 0);

    // 1: plain write sequence
    model_seq(0);
    pulse_req(1, 0);
    wait_quiet("t1", 3000);
    check_seq("t1");

    // 2: read back
    repeat ($urandom_range(3, 20)) @(negedge clk);
    model_seq(1);
    pulse_req(0, 1);
    wait_quiet("t2", 3000);
    check_seq("t2");
    chk("t2_rd_data_hold", rd_data, SEED + 8'd3);

    // 3: simultaneous edges, write then read back-to-back
    repeat ($urandom_range(3, 20)) @(negedge clk);
    seen_busy = 0;
    gap_max   = 0;
    model_seq(0);
    model_seq(1);
    pulse_req(1, 1);
    wait_quiet("t3", 6000);
    chk("t3_idle_gap", (gap_max <= 2), 1);
    check_seq("t3");

    // 4: two NACKs at 0x0001, then success
    set_nack(1, 2);
    model_seq(0);
    pulse_req(1, 0);
    wait_quiet("t4", 4000);
    c = 0;
    foreach (log_q[j]) if (log_q[j].addr == 16'h0001) c++;
    chk("t4_addr1_attempts", c, 3);
    check_seq("t4");
    clear_nack();

    // 5: persistent NACK at 0x0002
    set_nack(2, ALWAYS);
    model_seq(0);
    pulse_req(1, 0);
    wait_quiet("t5", 4000);
    c = 0;
    foreach (log_q[j]) if (log_q[j].addr == 16'h0002) c++;
    chk("t5_addr2_attempts", c, 1 + MAX_RETRY);
    c = 0;
    foreach (log_q[j]) if (log_q[j].addr == 16'h0003) c++;
    chk("t5_addr3_never", c, 0);
    check_seq("t5");
    clear_nack();

    // 6: asynchronous reset in the middle of byte 1's transfer
    pulse_req(1, 0);
    c = 0;
    while (log_q.size() < 2 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("t6_reached_byte1", log_q.size(), 2);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_req", req, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_addr", addr, 0);
    chk("t6_async_wdata", wdata, 0);
    chk("t6_async_rw", rw, 0);
    chk("t6_async_rd_data", rd_data, 0);
    chk("t6_async_rd_valid", rd_valid, 0);
    chk("t6_async_err", err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("t6_no_resume", log_q.size(), 2);
    chk("t6_idle_busy", busy, 0);
    clear_queues();
    model_seq(0);
    pulse_req(1, 0);
    wait_quiet("t6", 3000);
    check_seq("t6");

    // 7: randomized NACK patterns, direction and stale memory contents
    for (int k = 0; k < 4; k++) begin
      bit is_rd;
      is_rd = 1'($urandom);
      for (int i = 0; i < BYTE_NUM; i++) begin
        int n;
        n = $urandom_range(0, MAX_RETRY + 1);
        set_nack(i, (n > MAX_RETRY) ? ALWAYS : n);
        if (is_rd) begin
          stub_mem[i] = 8'($urandom);
          mdl_mem[i]  = stub_mem[i];
        end
      end
      repeat ($urandom_range(3, 20)) @(negedge clk);
      model_seq(is_rd);
      pulse_req(!is_rd, is_rd);
      wait_quiet("t7", 5000);
      check_seq("t7");
      clear_nack();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
